// File: rtl/core_fifo_pkg.sv
// Shared instruction-queue definitions, reused by the arbiter and the hazard-compare logic.
package core_fifo_pkg;

    localparam int INSTR_W = 32;

    // Instruction field positions decoded by the arbiter and hazard logic
    localparam int FORCE_BIT    = 28;
    localparam int CORE_SEL_BIT = 27;
    localparam int SRC_IS_MEM   = 23;
    localparam int DST_IS_MEM   = 22;

    typedef logic [INSTR_W-1:0] instr_t;

    function automatic logic is_forced(instr_t instr);
        return instr[FORCE_BIT];
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy control for core_instr_fifo: read/write pointers, count, flags and enables.
// Handshake: a push fires on push_valid && !full; a pop fires on pop_ready && !empty; flush overrides both.
module fifo_ptr_ctrl #(
    parameter  int DEPTH        = 8,
    parameter  int AFULL_THRESH = 6,
    localparam int PW           = $clog2(DEPTH),
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push_valid,
    input  logic          pop_ready,
    input  logic          bypass_take,
    output logic          wr_en,
    output logic          rd_en,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          overflow
);

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AFULL_THRESH));

    // A bypassed word is consumed straight from the input and never occupies storage
    assign wr_en = push_valid && !full && !flush && !bypass_take;
    assign rd_en = pop_ready && !empty && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
            if (push_valid && full) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/core_instr_fifo.sv
// Per-core instruction queue with FWFT pop port and oldest-first snapshot for hazard compare.
// Optional same-cycle empty bypass is enabled by defining CORE_FIFO_BYPASS_EN.
module core_instr_fifo #(
    parameter  int DEPTH        = 8,
    parameter  int INSTR_W      = 32,
    parameter  int AFULL_THRESH = 6,
    localparam int PW           = $clog2(DEPTH),
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [INSTR_W-1:0]       push_data,
    output logic                     push_ready,
    output logic                     pop_valid,
    output logic [INSTR_W-1:0]       pop_data,
    input  logic                     pop_ready,
    output logic [CW-1:0]            count,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [DEPTH*INSTR_W-1:0] snap_data,
    output logic [DEPTH-1:0]         snap_valid
);

    import core_fifo_pkg::*;

    logic          wr_en;
    logic          rd_en;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          bypass_act;
    logic          bypass_take;

    logic [INSTR_W-1:0] mem [DEPTH];

`ifdef CORE_FIFO_BYPASS_EN
    assign bypass_act  = empty && push_valid && !flush;
    assign bypass_take = bypass_act && pop_ready;
`else
    assign bypass_act  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    fifo_ptr_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_ptr_ctrl (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .push_valid   (push_valid),
        .pop_ready    (pop_ready),
        .bypass_take  (bypass_take),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .overflow     (overflow)
    );

    // Storage is deliberately not reset; every read path is masked by occupancy
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    assign push_ready = !full;
    assign pop_valid  = !empty || bypass_act;
    assign pop_data   = !empty    ? mem[rd_ptr] :
                        bypass_act ? push_data  : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_snap
        logic [PW-1:0] idx;
        assign idx = rd_ptr + PW'(i);
        assign snap_valid[i] = (CW'(i) < count);
        assign snap_data[i*INSTR_W +: INSTR_W] = snap_valid[i] ? mem[idx] : '0;
    end

endmodule

// File: tb/tb_core_instr_fifo.sv
// Self-checking bench for core_instr_fifo against a queue-based reference model.
module tb_core_instr_fifo;

    localparam int DEPTH = 8;
    localparam int W     = 32;
    localparam int AF    = 6;
    localparam int CW    = 4;
`ifdef CORE_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 push_valid;
    logic [W-1:0]         push_data;
    logic                 push_ready;
    logic                 pop_valid;
    logic [W-1:0]         pop_data;
    logic                 pop_ready;
    logic [CW-1:0]        count;
    logic                 almost_full;
    logic                 overflow;
    logic [DEPTH*W-1:0]   snap_data;
    logic [DEPTH-1:0]     snap_valid;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_q[$];
    logic [W-1:0] exp_q[$];
    logic         model_ovf;

    core_instr_fifo #(.DEPTH(DEPTH), .INSTR_W(W), .AFULL_THRESH(AF)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .pop_ready   (pop_ready),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .snap_data   (snap_data),
        .snap_valid  (snap_valid)
    );

    always #5 clk = ~clk;

    // Reference model: occupancy is a queue, oldest word at index 0
    function automatic logic model_pop_valid();
        return (model_q.size() > 0) || (BYP && push_valid && !flush);
    endfunction

    function automatic logic [W-1:0] model_pop_data();
        if (model_q.size() > 0) return model_q[0];
        if (BYP && push_valid && !flush) return push_data;
        return '0;
    endfunction

    function automatic logic [DEPTH*W-1:0] model_snap_data();
        logic [DEPTH*W-1:0] r = '0;
        for (int i = 0; i < model_q.size(); i++) r[i*W +: W] = model_q[i];
        return r;
    endfunction

    function automatic logic [DEPTH-1:0] model_snap_valid();
        logic [DEPTH-1:0] r = '0;
        for (int i = 0; i < model_q.size(); i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic model_edge(input logic pv, input logic [W-1:0] pd, input logic pr, input logic fl);
        int n = model_q.size();
        if (fl) begin
            model_q.delete();
            model_ovf = 1'b0;
            return;
        end
        if (BYP && n == 0 && pv && pr) return;
        if (pv && n == DEPTH) model_ovf = 1'b1;
        if (pr && n > 0) void'(model_q.pop_front());
        if (pv && n < DEPTH) model_q.push_back(pd);
    endtask

    // Driver: apply inputs for one clock, update the model at the edge, return at the next falling edge idle
    task automatic tick(input logic pv, input logic [W-1:0] pd, input logic pr, input logic fl);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        flush      = fl;
        @(posedge clk);
        model_edge(pv, pd, pr, fl);
        @(negedge clk);
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
        repeat (2) @(negedge clk);
        model_q.delete(); model_ovf = 1'b0;
        checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid got %b want 0", pop_valid); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
        checks++; if (almost_full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got af=%b ovf=%b want 0 0", almost_full, overflow); end
        checks++; if (snap_valid !== '0 || snap_data !== '0 || pop_data !== '0) begin errors++; $display("FAIL reset_masked got sv=%h pd=%h want 0 0", snap_valid, pop_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 3; k++) tick(1'b1, 32'hA000_0000 + W'(k), 1'b0, 1'b0);
        checks++; if (count !== 3) begin errors++; $display("FAIL basic_count got %0d want 3", count); end
        checks++; if (pop_valid !== 1'b1 || pop_data !== 32'hA000_0001) begin errors++; $display("FAIL basic_head got v=%b %h want 1 a0000001", pop_valid, pop_data); end
        checks++; if (snap_valid !== 8'b0000_0111) begin errors++; $display("FAIL basic_snap_valid got %b want 00000111", snap_valid); end
        checks++; if (snap_data[2*W +: W] !== 32'hA000_0003) begin errors++; $display("FAIL basic_slot2 got %h want a0000003", snap_data[2*W +: W]); end
    endtask

    task automatic test_overflow();
        logic found;
        for (int k = 4; k <= 8; k++) begin
            tick(1'b1, 32'hB000_0000 + W'(k), 1'b0, 1'b0);
            checks++; if (count !== CW'(k)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, k); end
            checks++; if (almost_full !== (k >= AF)) begin errors++; $display("FAIL fill_almost_full at %0d got %b want %b", k, almost_full, k >= AF); end
        end
        push_valid = 1'b1; push_data = 32'hDEAD_BEEF; #1;
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_push_ready got %b want 0", push_ready); end
        tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        checks++; if (count !== 8 || pop_data !== 32'hA000_0001) begin errors++; $display("FAIL ovf_state got cnt=%0d head=%h want 8 a0000001", count, pop_data); end
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) if (snap_data[i*W +: W] === 32'hDEAD_BEEF) found = 1'b1;
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL ovf_dropped got present=%b want 0", found); end
    endtask

    task automatic test_full_pop_push();
        tick(1'b1, 32'hC000_0001, 1'b1, 1'b0);
        checks++; if (count !== 7 || push_ready !== 1'b1) begin errors++; $display("FAIL fullpp_count got cnt=%0d rdy=%b want 7 1", count, push_ready); end
        checks++; if (pop_data !== 32'hA000_0002) begin errors++; $display("FAIL fullpp_head got %h want a0000002", pop_data); end
        tick(1'b1, 32'hC000_0001, 1'b0, 1'b0);
        checks++; if (count !== 8 || snap_data[7*W +: W] !== 32'hC000_0001) begin errors++; $display("FAIL fullpp_slot7 got cnt=%0d %h want 8 c0000001", count, snap_data[7*W +: W]); end
        checks++; if (snap_data !== model_snap_data()) begin errors++; $display("FAIL fullpp_snap got %h want %h", snap_data, model_snap_data()); end
    endtask

    task automatic test_flush();
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0);
        checks++; if (count !== 5 || overflow !== 1'b1) begin errors++; $display("FAIL preflush got cnt=%0d ovf=%b want 5 1", count, overflow); end
        tick(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b1);
        checks++; if (count !== 0 || pop_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got cnt=%0d pv=%b want 0 0", count, pop_valid); end
        checks++; if (overflow !== 1'b0 || snap_valid !== '0) begin errors++; $display("FAIL flush_clear got ovf=%b sv=%b want 0 0", overflow, snap_valid); end
    endtask

    task automatic test_stream();
        for (int v = 1; v <= 20; v++) exp_q.push_back(W'(v));
        for (int v = 1; v <= 3; v++) tick(1'b1, W'(v), 1'b0, 1'b0);
        for (int v = 4; v <= 23; v++) begin
            push_valid = (v <= 20); push_data = W'(v); pop_ready = 1'b1; #1;
            checks++; if (exp_q.size() == 0 || pop_data !== exp_q[0]) begin errors++; $display("FAIL stream_order got %h want %h", pop_data, exp_q.size() ? exp_q[0] : 32'h0); end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            tick(v <= 20, W'(v), 1'b1, 1'b0);
            checks++; if (count !== CW'(v <= 20 ? 3 : 23 - v)) begin errors++; $display("FAIL stream_count got %0d want %0d", count, v <= 20 ? 3 : 23 - v); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++) tick(1'b1, $urandom, 1'b0, 1'b0);
        push_valid = 1'b1; push_data = 32'h7777_7777;
        #2 reset = 1'b1;
        #1;
        model_q.delete(); model_ovf = 1'b0;
        checks++; if (count !== 0 || pop_valid !== 1'b0) begin errors++; $display("FAIL areset_now got cnt=%0d pv=%b want 0 0", count, pop_valid); end
        checks++; if (snap_valid !== '0 || push_ready !== 1'b1) begin errors++; $display("FAIL areset_flags got sv=%b rdy=%b want 0 1", snap_valid, push_ready); end
        push_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
        checks++; if (count !== 1 || snap_data[W-1:0] !== 32'h5A5A_0001) begin errors++; $display("FAIL areset_first got cnt=%0d slot0=%h want 1 5a5a0001", count, snap_data[W-1:0]); end
        tick(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_bypass();
        push_valid = 1'b1; push_data = 32'h1234_5678; pop_ready = 1'b1; #1;
        checks++; if (pop_valid !== model_pop_valid() || pop_data !== model_pop_data()) begin errors++; $display("FAIL bypass_same_cycle got v=%b %h want %b %h", pop_valid, pop_data, model_pop_valid(), model_pop_data()); end
        tick(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL bypass_count got %0d want %0d", count, model_q.size()); end
        if (model_q.size() > 0) tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b1, 32'h8765_4321, 1'b0, 1'b0);
        checks++; if (count !== 1 || pop_data !== 32'h8765_4321) begin errors++; $display("FAIL bypass_noready got cnt=%0d %h want 1 87654321", count, pop_data); end
        tick(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic pv, pr, fl;
        logic [W-1:0] pd;
        for (int c = 0; c < 400; c++) begin
            pv = ($urandom_range(0, 99) < 60);
            pr = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 3);
            pd = $urandom;
            push_valid = pv; push_data = pd; pop_ready = pr; flush = fl; #1;
            checks++; if (pop_valid !== model_pop_valid() || pop_data !== model_pop_data()) begin errors++; $display("FAIL rand_pop cyc %0d got v=%b %h want %b %h", c, pop_valid, pop_data, model_pop_valid(), model_pop_data()); end
            checks++; if (count !== CW'(model_q.size()) || push_ready !== (model_q.size() < DEPTH)) begin errors++; $display("FAIL rand_count cyc %0d got %0d rdy=%b want %0d", c, count, push_ready, model_q.size()); end
            checks++; if (almost_full !== (model_q.size() >= AF) || overflow !== model_ovf) begin errors++; $display("FAIL rand_flags cyc %0d got af=%b ovf=%b want %b %b", c, almost_full, overflow, model_q.size() >= AF, model_ovf); end
            checks++; if (snap_valid !== model_snap_valid() || snap_data !== model_snap_data()) begin errors++; $display("FAIL rand_snap cyc %0d got %b %h want %b %h", c, snap_valid, snap_data, model_snap_valid(), model_snap_data()); end
            tick(pv, pd, pr, fl);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop_push();
        test_flush();
        test_stream();
        test_async_reset();
        test_bypass();
        tick(1'b0, '0, 1'b0, 1'b1);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_instr_fifo.md
Name: core_instr_fifo

Overview:
Per-core instruction queue that sits downstream of the dual-core instruction arbiter. There is one instance per core, fed by the arbiter's FIFO_1 or FIFO_2 output. It buffers dispatched instructions and hands them to the core's fetch/decode stage using a valid/ready handshake. It also exports a snapshot of all resident entries, oldest first, with a valid mask, so the arbiter can run its cross-core register hazard compare against real occupancy instead of a shift register.

Parameters:
DEPTH, 8, number of instruction entries; power of two, minimum 2
INSTR_W, 32, instruction width in bits
AFULL_THRESH, 6, count at or above which almost_full asserts

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all entries
push_valid  in  1  arbiter presents an instruction
push_data  in  INSTR_W  instruction from arbiter
push_ready  out  1  entry available (not full)
pop_valid  out  1  head entry valid
pop_data  out  INSTR_W  head instruction, first-word fall-through
pop_ready  in  1  core accepts head
count  out  $clog2(DEPTH+1)  current occupancy
almost_full  out  1  count >= AFULL_THRESH
overflow  out  1  sticky: push attempted while full
snap_data  out  DEPTH*INSTR_W  entries oldest-first; slot 0 = head, in bits [INSTR_W-1:0]
snap_valid  out  DEPTH  bit i set when slot i is occupied (thermometer from bit 0)

Behaviour:
- Reset (asynchronous, active-high) clears:
  - rd_ptr, wr_ptr, count = 0; overflow = 0.
  - pop_valid = 0, push_ready = 1, almost_full = 0, snap_valid = 0.
  - Storage contents are don't-care, but pop_data and snap_data are masked to 0 while the matching valid bit is low.
- Pointers are log2(DEPTH) bits and wrap naturally. A separate count register disambiguates full from empty.
- Push occurs when push_valid && push_ready. Data is written at wr_ptr, then wr_ptr+1.
- Pop occurs when pop_valid && pop_ready, then rd_ptr+1.
- Simultaneous push and pop:
  - Not full and not empty: count unchanged; both pointers advance.
  - Full: push_ready = 0, so only the pop happens. push_ready rises the next cycle; there is no same-cycle pass-through.
  - Empty: only the push happens (see macro below).
- Latency: a pushed word is visible on pop_data / pop_valid the cycle after the push edge. Pop_data is combinational from storage[rd_ptr] (FWFT).
- Push while full: the data is dropped, overflow sets to 1 and stays set until reset or flush. Storage and pointers are unchanged.
- Pop while empty: no-op; no flag.
- Flush has priority over push and pop in the same cycle: pointers = 0, count = 0, overflow = 0. Any push in the flush cycle is discarded.
- almost_full and push_ready are combinational from count.
- snap_data slot i = storage[(rd_ptr+i) mod DEPTH]; snap_valid[i] = (i < count). Both are combinational from registers.
- Reset asserted mid-transfer aborts the transfer. There is no partial state, and the first push after reset deassertion lands in slot 0.

Optional Feature:
CORE_FIFO_BYPASS_EN
- Defined: when empty and push_valid is high, pop_valid = 1 and pop_data = push_data in the same cycle (combinational bypass).
  - If pop_ready is also high, the word is consumed without being written and count stays 0.
  - If pop_ready is low, the word is written normally.
- Undefined: no bypass; minimum latency is 1 cycle as described in Behaviour.

Decomposition:
- Shared package core_fifo_pkg holds:
  - INSTR_W.
  - Instruction field constants: FORCE_BIT=28, CORE_SEL_BIT=27, DST_IS_MEM=22, SRC_IS_MEM=23.
  - An instr_t typedef.
  - These constants are reused by the arbiter and hazard logic.
- One sub-module, fifo_ptr_ctrl, is natural. It owns the pointers, count, full/empty, almost_full and overflow, and issues the write and read enables.
- The top level holds the storage array, pop_data mux, snapshot rotation and bypass mux.

Test Plan:
1. Reset, then push 0xA0000001..0xA0000003 on consecutive cycles with pop_ready=0 -> count=3; pop_data=0xA0000001; snap_valid=8'b0000_0111; snap slot 2 = 0xA0000003.
2. Fill to 8 entries, then push 0xDEADBEEF -> push_ready=0, overflow=1, count stays 8, the head is unchanged and 0xDEADBEEF never appears; almost_full is high from count=6.
3. With the FIFO full, hold push_valid and pop_ready for one cycle -> only the pop occurs and count=7; the next cycle push_ready=1 and the push lands, giving count=8 with the new word in slot 7.
4. Push and pop continuously for 20 cycles with values 1..20 -> pop order is 1..20, pointers wrap past 7 with no loss, and count stays constant.
5. Assert flush together with push_valid (count=5, overflow=1) -> next cycle count=0, pop_valid=0, overflow=0, snap_valid=0.
6. Assert reset asynchronously mid-cycle at count=4 -> outputs clear immediately without a clock edge; with CORE_FIFO_BYPASS_EN, push 0x12345678 with pop_ready=1 on the empty FIFO -> same-cycle pop_valid=1, pop_data=0x12345678, count stays 0.
